// File: rtl/ws2812_chain_driver_pkg.sv
// Shared definitions for the WS2812 chain driver: state encoding, pixel width and
// default 100 MHz bit timing.
package ws2812_chain_driver_pkg;

  localparam int PIXEL_W      = 24;
  localparam int DEF_NUM_LEDS = 2;
  localparam int DEF_T0H_CYC  = 35;
  localparam int DEF_T0L_CYC  = 80;
  localparam int DEF_T1H_CYC  = 70;
  localparam int DEF_T1L_CYC  = 60;
  localparam int DEF_RET_CYC  = 5000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_LATCH = 3'd4
  } state_e;

  function automatic int max5(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/ws2812_chain_driver_if.sv
// Pixel stream and serial/status bundle between a pixel source (master) and the
// chain driver (slave).
interface ws2812_chain_driver_if;

  logic                                        i_start;
  logic [ws2812_chain_driver_pkg::PIXEL_W-1:0] i_pixel;
  logic                                        i_pixel_valid;
  logic                                        o_pixel_ready;
  logic                                        o_serial;
  logic                                        o_busy;
  logic                                        o_done;
  logic                                        o_underrun;

  modport master (
    output i_start, i_pixel, i_pixel_valid,
    input  o_pixel_ready, o_serial, o_busy, o_done, o_underrun
  );

  modport slave (
    input  i_start, i_pixel, i_pixel_valid,
    output o_pixel_ready, o_serial, o_busy, o_done, o_underrun
  );

endinterface

// File: rtl/ws2812_bit_encoder.sv
// Times one WS2812 bit: a go strobe starts the HIGH phase, then the LOW phase follows.
// o_high_done / o_bit_done mark the last cycle of each phase; a go on that cycle chains seamlessly.
module ws2812_bit_encoder
  import ws2812_chain_driver_pkg::*;
#(
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T0L_CYC = DEF_T0L_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC,
  parameter int T1L_CYC = DEF_T1L_CYC,
  parameter int CNT_W   = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_go,
  input  logic i_bit,
  output logic o_high_done,
  output logic o_bit_done
);

  localparam logic [CNT_W-1:0] H0_LAST = CNT_W'(T0H_CYC - 1);
  localparam logic [CNT_W-1:0] L0_LAST = CNT_W'(T0L_CYC - 1);
  localparam logic [CNT_W-1:0] H1_LAST = CNT_W'(T1H_CYC - 1);
  localparam logic [CNT_W-1:0] L1_LAST = CNT_W'(T1L_CYC - 1);

  logic             act_q, act_d;
  logic             low_q, low_d;
  logic             bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_q <= 1'b0;
      low_q <= 1'b0;
      bit_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      act_q <= act_d;
      low_q <= low_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    act_d = act_q;
    low_d = low_q;
    bit_d = bit_q;
    cnt_d = cnt_q;
    if (i_go) begin
      act_d = 1'b1;
      low_d = 1'b0;
      bit_d = i_bit;
      cnt_d = i_bit ? H1_LAST : H0_LAST;
    end else if (act_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (!low_q) begin
        low_d = 1'b1;
        cnt_d = bit_q ? L1_LAST : L0_LAST;
      end else begin
        act_d = 1'b0;
      end
    end
  end

  assign o_high_done = act_q & ~low_q & (cnt_q == '0);
  assign o_bit_done  = act_q &  low_q & (cnt_q == '0);

endmodule

// File: rtl/ws2812_chain_driver.sv
// Frame sequencer for a daisy-chained WS2812 string: one-entry pixel buffer, MSB-first
// serializer and post-frame latch period. Reset enters the latch so the chain starts clean.
module ws2812_chain_driver
  import ws2812_chain_driver_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T0L_CYC  = DEF_T0L_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int T1L_CYC  = DEF_T1L_CYC,
  parameter int RET_CYC  = DEF_RET_CYC
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  ws2812_chain_driver_if.slave   bus
);

  localparam int CNT_W = $clog2(max5(T0H_CYC, T0L_CYC, T1H_CYC, T1L_CYC, RET_CYC) + 1);
  localparam int PIX_W = $clog2(NUM_LEDS + 1);
  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_CYC - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_LEDS - 1);

  state_e               state_q, state_d;
  logic [PIXEL_W-1:0]   buf_q, buf_d;
  logic                 full_q, full_d;
  logic [PIXEL_W-2:0]   sh_q, sh_d;
  logic [4:0]           idx_q, idx_d;
  logic [PIX_W-1:0]     pix_q, pix_d;
  logic [CNT_W-1:0]     lat_q, lat_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;
  logic                 unr_q, unr_d;
  logic                 por_q, por_d;

  logic enc_go, enc_bit, high_done, bit_done;
  logic load_px, shift_bit, unr_set, latch_end, start_acc, push, busy;

  ws2812_bit_encoder #(
    .T0H_CYC(T0H_CYC), .T0L_CYC(T0L_CYC),
    .T1H_CYC(T1H_CYC), .T1L_CYC(T1L_CYC),
    .CNT_W  (CNT_W)
  ) u_enc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_go       (enc_go),
    .i_bit      (enc_bit),
    .o_high_done(high_done),
    .o_bit_done (bit_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_LATCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.i_start) state_d = ST_FETCH;
      ST_FETCH: if (full_q) state_d = ST_HIGH;
      ST_HIGH:  if (high_done) state_d = ST_LOW;
      ST_LOW: begin
        if (bit_done) begin
          if (idx_q != 5'd0)         state_d = ST_HIGH;
          else if (pix_q == PIX_LAST) state_d = ST_LATCH;
          else if (full_q)            state_d = ST_HIGH;
          else                        state_d = ST_LATCH;
        end
      end
      ST_LATCH: if (lat_q == RET_LAST) state_d = ST_IDLE;
      default:  state_d = ST_LATCH;
    endcase
  end

  // Pixel loads happen either from FETCH or back-to-back at the end of a pixel's last bit.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    start_acc = (state_q == ST_IDLE) & bus.i_start;
    load_px   = ((state_q == ST_FETCH) & full_q) |
                ((state_q == ST_LOW) & bit_done & (idx_q == 5'd0) & (pix_q != PIX_LAST) & full_q);
    shift_bit = (state_q == ST_LOW) & bit_done & (idx_q != 5'd0);
    unr_set   = (state_q == ST_LOW) & bit_done & (idx_q == 5'd0) & (pix_q != PIX_LAST) & ~full_q;
    latch_end = (state_q == ST_LATCH) & (lat_q == RET_LAST);
    enc_go    = load_px | shift_bit;
    enc_bit   = load_px ? buf_q[PIXEL_W-1] : sh_q[PIXEL_W-2];
    push      = bus.i_pixel_valid & ~full_q & busy;
  end

  always_comb begin
    buf_d    = buf_q;
    full_d   = full_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    pix_d    = pix_q;
    unr_d    = unr_q;
    por_d    = por_q;
    lat_d    = '0;
    serial_d = (state_d == ST_HIGH);
    done_d   = latch_end & ~por_q;
    if (push) begin
      buf_d  = bus.i_pixel;
      full_d = 1'b1;
    end
    if (load_px) begin
      full_d = 1'b0;
      sh_d   = buf_q[PIXEL_W-2:0];
      idx_d  = 5'd23;
      if (state_q == ST_LOW) pix_d = pix_q + PIX_W'(1);
    end else if (shift_bit) begin
      sh_d  = {sh_q[PIXEL_W-3:0], 1'b0};
      idx_d = idx_q - 5'd1;
    end
    if (start_acc) begin
      pix_d = '0;
      unr_d = 1'b0;
    end
    if (unr_set) unr_d = 1'b1;
    if ((state_q == ST_LATCH) && !latch_end) lat_d = lat_q + CNT_W'(1);
    if (latch_end) por_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_q    <= '0;
      full_q   <= 1'b0;
      sh_q     <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      lat_q    <= '0;
      serial_q <= 1'b0;
      done_q   <= 1'b0;
      unr_q    <= 1'b0;
      por_q    <= 1'b1;
    end else begin
      buf_q    <= buf_d;
      full_q   <= full_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      pix_q    <= pix_d;
      lat_q    <= lat_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      unr_q    <= unr_d;
      por_q    <= por_d;
    end
  end

  assign bus.o_pixel_ready = ~full_q & busy;
  assign bus.o_serial      = serial_q;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done_q;
  assign bus.o_underrun    = unr_q;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Bench for ws2812_chain_driver: a two-LED chain decoder on o_serial plus scoreboards of
// expected bit timings and frame completions.
`timescale 1ns/1ps
module tb_ws2812_chain_driver;

  localparam int RET = 5000;
  localparam int LONG_LOW = 2500;

  typedef struct { int hi; int lo; } bit_t;
  typedef struct { logic unr; logic [23:0] l0; logic [23:0] l1; } done_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  bit_t  bitq[$];
  done_t doneq[$];

  // chain model state
  int          m_hi, m_lo, m_nbits, m_pend_lo;
  logic        m_pend_vld;
  logic [23:0] m_sh0, m_sh1, led0, led1;

  ws2812_chain_driver_if bus();

  ws2812_chain_driver dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Chain decoder: first 24 bits go to led0, next 24 to led1, committed on a long low.
  always @(negedge clk) begin
    bit_t  eb;
    done_t ed;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_nbits = 0; m_pend_vld = 1'b0;
    end else begin
      if (bus.o_done) begin
        if (doneq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          ed = doneq.pop_front();
          chk("done_prior_bit", m_pend_vld, 1);
          chk("latch_len", m_lo, m_pend_lo + RET);
          chk("done_underrun", bus.o_underrun, ed.unr);
          chk("done_busy", bus.o_busy, 0);
          chk("led0", led0, ed.l0);
          chk("led1", led1, ed.l1);
        end
      end
      if (bus.o_serial) begin
        if (m_hi == 0 && m_pend_vld && m_lo < LONG_LOW) chk("low_width", m_lo, m_pend_lo);
        if (m_hi == 0) m_pend_vld = 1'b0;
        m_hi++;
        m_lo = 0;
      end else begin
        if (m_hi > 0) begin
          if (bitq.size() == 0) chk("bit_unexpected", 1, 0);
          else begin
            eb = bitq.pop_front();
            chk("high_width", m_hi, eb.hi);
            m_pend_lo  = eb.lo;
            m_pend_vld = 1'b1;
          end
          if (m_nbits < 24)      m_sh0[23 - m_nbits] = (m_hi >= 53);
          else if (m_nbits < 48) m_sh1[47 - m_nbits] = (m_hi >= 53);
          m_nbits++;
          m_hi = 0;
        end
        m_lo++;
        if (m_lo == LONG_LOW && m_nbits > 0) begin
          if (m_nbits >= 24) led0 = m_sh0;
          if (m_nbits >= 48) led1 = m_sh1;
          m_nbits = 0;
        end
      end
    end
  end

  task automatic send_pixel(input logic [23:0] px);
    bit_t b;
    int   n;
    bus.i_pixel       = px;
    bus.i_pixel_valid = 1'b1;
    n = 0;
    while (!bus.o_pixel_ready && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", bus.o_pixel_ready, 1);
    for (int i = 23; i >= 0; i--) begin
      b.hi = px[i] ? 70 : 35;
      b.lo = px[i] ? 60 : 80;
      bitq.push_back(b);
    end
    @(posedge clk); #1;
    bus.i_pixel_valid = 1'b0;
  endtask

  task automatic start_frame(input logic unr, input logic [23:0] l0, input logic [23:0] l1);
    done_t d;
    d.unr = unr; d.l0 = l0; d.l1 = l1;
    doneq.push_back(d);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    chk("start_clears_underrun", bus.o_underrun, 0);
    chk("start_busy", bus.o_busy, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.o_busy && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", bus.o_busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic latch_check();
    int   n;
    logic hi_seen;
    n = 0; hi_seen = 1'b0;
    while (bus.o_busy && n < RET + 100) begin
      if (bus.o_serial || bus.o_done) hi_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("latch_cycles", n, RET);
    chk("latch_quiet", hi_seen, 0);
    chk("latch_no_done", bus.o_done, 0);
  endtask

  task automatic wait_bit(input int nb);
    int n;
    n = 0;
    while (!(m_nbits >= nb && bus.o_serial) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bit_wait", (m_nbits >= nb) && bus.o_serial, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_pixel = '0;
    bus.i_pixel_valid = 1'b0;
    led0 = '0; led1 = '0; m_sh0 = '0; m_sh1 = '0; m_pend_lo = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.o_busy, 1);
    chk("rst_serial", bus.o_serial, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_underrun", bus.o_underrun, 0);
    chk("rst_ready", bus.o_pixel_ready, 1);
    rst = 1'b0;
    latch_check();

    // two pixels supplied ahead of need
    start_frame(1'b0, 24'hF0F0FF, 24'hF0F0FF);
    send_pixel(24'hF0F0FF);
    send_pixel(24'hF0F0FF);
    wait_idle();
    chk("frame_underrun", bus.o_underrun, 0);

    // second pixel withheld
    start_frame(1'b1, 24'h00FF00, 24'hF0F0FF);
    send_pixel(24'h00FF00);
    wait_idle();
    chk("underrun_sticky", bus.o_underrun, 1);

    // alternating bits, back-to-back pixels, stray start during bit 5
    start_frame(1'b0, 24'hAAAAAA, 24'hAAAAAA);
    send_pixel(24'hAAAAAA);
    send_pixel(24'hAAAAAA);
    wait_bit(5);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    wait_idle();
    chk("ignored_start_underrun", bus.o_underrun, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("ignored_start_idle", bus.o_busy, 0);

    // reset in the middle of a pixel
    start_frame(1'b0, 24'h5A5A5A, 24'hC3C3C3);
    send_pixel(24'h5A5A5A);
    send_pixel(24'hC3C3C3);
    wait_bit(10);
    rst = 1'b1;
    bitq.delete();
    doneq.delete();
    #1;
    chk("midrst_serial", bus.o_serial, 0);
    chk("midrst_buf_empty", bus.o_pixel_ready, 1);
    chk("midrst_busy", bus.o_busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    latch_check();
    start_frame(1'b0, 24'h123456, 24'h789ABC);
    send_pixel(24'h123456);
    send_pixel(24'h789ABC);
    wait_idle();

    chk("bitq_drained", bitq.size(), 0);
    chk("doneq_drained", doneq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
